// File: rtl/serial_frame_deser.sv
// Sync-hunting bit-to-byte frame deserializer with idle-timeout abort.
// Optional trailing mod-256 checksum byte when SERIAL_FRAME_CHECKSUM_EN is defined.
module serial_frame_deser #(
  parameter logic [15:0] SYNC_WORD = 16'hEB90,
  parameter int          FRAME_LEN = 256,
  parameter int          TIMEOUT   = 4096
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        bit_in,
  input  logic        bit_en,
  output logic [7:0]  byte_out,
  output logic        byte_vld,
  output logic        sof,
  output logic        eof,
  output logic        frame_ok,
  output logic        frame_err,
  output logic        locked,
  output logic [15:0] frame_cnt
);

  localparam int             IW        = $clog2(TIMEOUT);
  localparam logic [IW-1:0]  IDLE_LAST = IW'(TIMEOUT - 1);
  localparam logic [15:0]    LAST_IDX  = 16'(FRAME_LEN - 1);

`ifdef SERIAL_FRAME_CHECKSUM_EN
  typedef enum logic [1:0] {ST_HUNT, ST_PAYLOAD, ST_CHECK} state_t;
  logic [7:0]    r_sum;
`else
  typedef enum logic [1:0] {ST_HUNT, ST_PAYLOAD} state_t;
`endif

  state_t        r_state;
  logic [14:0]   r_sync_sr;
  logic [6:0]    r_byte_sr;
  logic [2:0]    r_bit_cnt;
  logic [15:0]   r_byte_cnt;
  logic [IW-1:0] r_idle;

  logic [15:0]   w_sync_next;
  logic [7:0]    w_byte_next;
  logic          w_byte_done;
  logic          w_idle_hit;

  assign w_sync_next = {r_sync_sr, bit_in};
  assign w_byte_next = {r_byte_sr, bit_in};
  assign w_byte_done = bit_en && (r_bit_cnt == 3'd7);
  // A strobe in the cycle the idle count would expire always wins.
  assign w_idle_hit  = !bit_en && (r_idle == IDLE_LAST);

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_state    <= ST_HUNT;
      r_sync_sr  <= '0;
      r_byte_sr  <= '0;
      r_bit_cnt  <= '0;
      r_byte_cnt <= '0;
      r_idle     <= '0;
`ifdef SERIAL_FRAME_CHECKSUM_EN
      r_sum      <= '0;
`endif
      byte_out   <= '0;
      byte_vld   <= 1'b0;
      sof        <= 1'b0;
      eof        <= 1'b0;
      frame_ok   <= 1'b0;
      frame_err  <= 1'b0;
      locked     <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      byte_vld  <= 1'b0;
      sof       <= 1'b0;
      eof       <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;

      if (bit_en)
        r_idle <= '0;
      else if (r_idle != IDLE_LAST)
        r_idle <= r_idle + 1'b1;

      case (r_state)
        ST_HUNT: begin
          if (bit_en) begin
            if (w_sync_next == SYNC_WORD) begin
              // Shift register is cleared here so the next hunt starts fresh.
              r_state    <= ST_PAYLOAD;
              locked     <= 1'b1;
              r_sync_sr  <= '0;
              r_bit_cnt  <= '0;
              r_byte_cnt <= '0;
`ifdef SERIAL_FRAME_CHECKSUM_EN
              r_sum      <= '0;
`endif
            end else begin
              r_sync_sr <= w_sync_next[14:0];
            end
          end
        end

        ST_PAYLOAD: begin
          if (bit_en) begin
            r_bit_cnt <= r_bit_cnt + 3'd1;
            r_byte_sr <= w_byte_next[6:0];
            if (w_byte_done) begin
              byte_out   <= w_byte_next;
              byte_vld   <= 1'b1;
              sof        <= (r_byte_cnt == 16'd0);
              eof        <= (r_byte_cnt == LAST_IDX);
              r_byte_cnt <= r_byte_cnt + 16'd1;
`ifdef SERIAL_FRAME_CHECKSUM_EN
              r_sum      <= r_sum + w_byte_next;
              if (r_byte_cnt == LAST_IDX)
                r_state <= ST_CHECK;
`else
              if (r_byte_cnt == LAST_IDX) begin
                r_state   <= ST_HUNT;
                locked    <= 1'b0;
                frame_ok  <= 1'b1;
                frame_cnt <= frame_cnt + 16'd1;
              end
`endif
            end
          end else if (w_idle_hit) begin
            r_state   <= ST_HUNT;
            locked    <= 1'b0;
            frame_err <= 1'b1;
          end
        end

`ifdef SERIAL_FRAME_CHECKSUM_EN
        ST_CHECK: begin
          if (bit_en) begin
            r_bit_cnt <= r_bit_cnt + 3'd1;
            r_byte_sr <= w_byte_next[6:0];
            if (w_byte_done) begin
              r_state <= ST_HUNT;
              locked  <= 1'b0;
              if (w_byte_next == r_sum) begin
                frame_ok  <= 1'b1;
                frame_cnt <= frame_cnt + 16'd1;
              end else begin
                frame_err <= 1'b1;
              end
            end
          end else if (w_idle_hit) begin
            r_state   <= ST_HUNT;
            locked    <= 1'b0;
            frame_err <= 1'b1;
          end
        end
`endif

        default: begin
          r_state <= ST_HUNT;
          locked  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_deser.sv
// Directed bench for serial_frame_deser (FRAME_LEN=4, TIMEOUT=16) with a byte/frame scoreboard.
module tb_serial_frame_deser;
  localparam int FL = 4;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        RST = 1'b1;
  logic        bit_in = 1'b0;
  logic        bit_en = 1'b0;
  logic [7:0]  byte_out;
  logic        byte_vld, sof, eof, frame_ok, frame_err, locked;
  logic [15:0] frame_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int exp_cnt = 0;

  logic [9:0] exp_q[$];   // {byte, sof, eof}
  bit         frm_q[$];   // 1 = frame_ok expected, 0 = frame_err expected

  serial_frame_deser #(.SYNC_WORD(16'hEB90), .FRAME_LEN(FL), .TIMEOUT(TO)) dut (
    .clk(clk), .RST(RST), .bit_in(bit_in), .bit_en(bit_en),
    .byte_out(byte_out), .byte_vld(byte_vld), .sof(sof), .eof(eof),
    .frame_ok(frame_ok), .frame_err(frame_err), .locked(locked), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $error("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: compare every output strobe at the falling edge.
  always @(negedge clk) begin
    if (!RST) begin
      if (byte_vld) begin
        n_cmp++;
        assert (exp_q.size() != 0) else begin
          n_err++;
          $error("FAIL unexpected_byte: observed %0h expected none", byte_out);
        end
        if (exp_q.size() != 0) begin
          logic [9:0] e;
          e = exp_q.pop_front();
          n_cmp++;
          assert ({byte_out, sof, eof} === e) else begin
            n_err++;
            $error("FAIL byte_sof_eof: observed %0h/%0b/%0b expected %0h/%0b/%0b",
                   byte_out, sof, eof, e[9:2], e[1], e[0]);
          end
`ifndef SERIAL_FRAME_CHECKSUM_EN
          n_cmp++;
          assert (frame_ok === e[0]) else begin
            n_err++;
            $error("FAIL ok_with_eof: observed %0b expected %0b", frame_ok, e[0]);
          end
`endif
        end
      end
      if (frame_ok || frame_err) begin
        n_cmp++;
        assert (frm_q.size() != 0) else begin
          n_err++;
          $error("FAIL unexpected_frame_evt: observed ok=%0b err=%0b expected none", frame_ok, frame_err);
        end
        if (frm_q.size() != 0) begin
          bit g;
          g = frm_q.pop_front();
          n_cmp++;
          assert ({frame_ok, frame_err} === {g, ~g}) else begin
            n_err++;
            $error("FAIL frame_evt: observed ok=%0b err=%0b expected ok=%0b err=%0b",
                   frame_ok, frame_err, g, ~g);
          end
        end
      end
    end
  end

  // Drivers: callers are always aligned to 1ns after a rising edge.
  task automatic send_bit(input logic b);
    bit_in = b;
    bit_en = 1'b1;
    @(posedge clk); #1;
    bit_en = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_sync();
    logic [15:0] s;
    s = 16'hEB90;
    for (int i = 15; i >= 0; i--) send_bit(s[i]);
  endtask

  function automatic logic [7:0] sum4(input logic [31:0] p);
    return p[31:24] + p[23:16] + p[15:8] + p[7:0];
  endfunction

  task automatic expect_frame(input logic [31:0] p, input logic [7:0] ck);
    bit good;
    for (int i = 0; i < FL; i++)
      exp_q.push_back({p[31-8*i -: 8], (i == 0), (i == FL-1)});
`ifdef SERIAL_FRAME_CHECKSUM_EN
    good = (ck == sum4(p));
`else
    good = 1'b1;
`endif
    frm_q.push_back(good);
    if (good) exp_cnt++;
  endtask

  task automatic send_payload(input logic [31:0] p, input logic [7:0] ck);
    for (int i = 0; i < FL; i++) send_byte(p[31-8*i -: 8]);
`ifdef SERIAL_FRAME_CHECKSUM_EN
    send_byte(ck);
`endif
  endtask

  task automatic send_frame(input logic [31:0] p, input logic [7:0] ck);
    send_sync();
    expect_frame(p, ck);
    send_payload(p, ck);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_byte_out"},  byte_out,  0);
    chk({tag, "_strobes"},   {byte_vld, sof, eof, frame_ok, frame_err, locked}, 0);
    chk({tag, "_frame_cnt"}, frame_cnt, 0);
  endtask

  initial begin
    logic [31:0] p;
    logic [7:0]  b1;

    // Reset state
    idle(3);
    chk_all_zero("reset");
    @(posedge clk); #1;
    RST = 1'b0;
    idle(3);
    chk("post_release_locked", locked, 0);

    // Basic frame
    p = 32'h01A53CFF;
    send_sync();
    chk("lock_after_sync", locked, 1);
    expect_frame(p, sum4(p));
    send_payload(p, sum4(p));
    chk("frame1_cnt", frame_cnt, exp_cnt);
    chk("frame1_unlocked", locked, 0);
    idle(3);

    // Noise before sync: lock only after the full sync word
    send_byte(8'hEB);
    send_byte(8'h10);
    chk("noise_no_lock", locked, 0);
    b1 = 8'hEB; send_byte(b1);
    for (int i = 7; i >= 1; i--) send_bit(i == 7 || i == 4);
    chk("sync15_no_lock", locked, 0);
    send_bit(1'b0);
    chk("sync16_lock", locked, 1);
    p = 32'h7E00C381;
    expect_frame(p, sum4(p));
    send_payload(p, sum4(p));
    chk("noise_frame_cnt", frame_cnt, exp_cnt);

    // Back-to-back frames, the second with checksum-test payload
    p = 32'h10203040;
    send_frame(p, 8'hA0);
    send_frame(p, 8'hA1);
    chk("b2b_cnt", frame_cnt, exp_cnt);
    chk("b2b_unlocked", locked, 0);
    idle(4);

    // Idle timeout after two payload bytes
    send_sync();
    exp_q.push_back({8'hC3, 1'b1, 1'b0});
    exp_q.push_back({8'h5A, 1'b0, 1'b0});
    frm_q.push_back(1'b0);
    send_byte(8'hC3);
    send_byte(8'h5A);
    for (int k = 1; k < TO; k++) begin
      @(posedge clk); #1;
      chk("timeout_early_err", frame_err, 0);
    end
    @(posedge clk); #1;
    chk("timeout_err", frame_err, 1);
    chk("timeout_unlocked", locked, 0);
    @(posedge clk); #1;
    chk("timeout_err_pulse", frame_err, 0);
    chk("timeout_cnt", frame_cnt, exp_cnt);

    // New sync after abort locks normally
    p = 32'hDEADBEEF;
    send_frame(p, sum4(p));
    chk("relock_cnt", frame_cnt, exp_cnt);

    // Bit on the exact timeout cycle wins
    p = 32'h5AA5F00F;
    send_sync();
    expect_frame(p, sum4(p));
    send_byte(p[31:24]);
    b1 = p[23:16];
    send_bit(b1[7]);
    idle(TO - 1);
    chk("edge_still_locked", locked, 1);
    for (int i = 6; i >= 0; i--) send_bit(b1[i]);
    chk("edge_no_err", frame_err, 0);
    send_byte(p[15:8]);
    send_byte(p[7:0]);
`ifdef SERIAL_FRAME_CHECKSUM_EN
    send_byte(sum4(p));
`endif
    chk("edge_cnt", frame_cnt, exp_cnt);
    idle(2);

    // Reset mid-byte in PAYLOAD
    send_sync();
    exp_q.push_back({8'h99, 1'b1, 1'b0});
    send_byte(8'h99);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    #2;
    RST = 1'b1;
    #1;
    chk_all_zero("midreset");
    exp_cnt = 0;
    idle(2);
    @(posedge clk); #1;
    RST = 1'b0;
    idle(3);
    chk("after_reset_locked", locked, 0);
    p = 32'h01A53CFF;
    send_frame(p, sum4(p));
    chk("after_reset_cnt", frame_cnt, exp_cnt);
    idle(4);

    chk("exp_q_drained", exp_q.size(), 0);
    chk("frm_q_drained", frm_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
